// File: rtl/uart_tx_ctrl_if.sv
// TX FIFO read port between the UART transmit sequencer (master) and the FIFO (slave).
// The FIFO is show-ahead: RData is valid whenever Empty is low; RInc pops the head word.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  Empty;
  logic [DATA_WIDTH-1:0] RData;
  logic                  RInc;

  modport master (input Empty, input RData, output RInc);
  modport slave  (output Empty, output RData, input RInc);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops a FIFO word, snapshots config, and serialises
// start, data (LSB first), optional parity and one or two stop bits onto TXD.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHAR_BITS  = 8,
  parameter int unsigned DIV_WIDTH  = 20
) (
  input  logic                 UCLK,
  input  logic                 reset,
  input  logic [3:0]           Cntrl,
  input  logic [DIV_WIDTH-1:0] BaudDiv,
  uart_tx_ctrl_if.master       fifo,
  output logic                 TXD,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int unsigned IdxW = (CHAR_BITS > 1) ? $clog2(CHAR_BITS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   cnt_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [CHAR_BITS-1:0]   shift_q;
  logic [IdxW-1:0]        idx_q;
  logic                   acc_q;
  logic                   txd_q;
  // Snapshot of Cntrl[3:1]: [0] parity_en, [1] parity_odd, [2] two_stop.
  logic [2:0]             cfg_q;

  logic tick;
  logic start;
  logic last_bit;
  logic unused_rdata;

  assign tick     = (cnt_q == div_q);
  assign start    = (state_q == StIdle) && Cntrl[0] && !fifo.Empty;
  assign last_bit = (idx_q == IdxW'(CHAR_BITS - 1));

  assign fifo.RInc = start;
  assign TXD       = txd_q;
  assign TxBusy    = (state_q != StIdle);
  assign TxDone    = tick && (((state_q == StStop1) && !cfg_q[2]) || (state_q == StStop2));

  // Only the low CHAR_BITS of the FIFO word carry character data.
  assign unused_rdata = ^fifo.RData[DATA_WIDTH-1:CHAR_BITS];

  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      txd_q   <= 1'b1;
      cfg_q   <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + DIV_WIDTH'(1);
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          txd_q <= 1'b1;
          if (start) begin
            shift_q <= fifo.RData[CHAR_BITS-1:0];
            cfg_q   <= Cntrl[3:1];
            div_q   <= BaudDiv;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            txd_q   <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            acc_q   <= acc_q ^ shift_q[0];
            idx_q   <= idx_q + IdxW'(1);
            if (!last_bit) begin
              txd_q <= shift_q[1];
            end else if (cfg_q[0]) begin
              // Accumulator does not yet include the bit currently on the line.
              txd_q   <= acc_q ^ shift_q[0] ^ cfg_q[1];
              state_q <= StParity;
            end else begin
              txd_q   <= 1'b1;
              state_q <= StStop1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            txd_q   <= 1'b1;
            state_q <= StStop1;
          end
        end
        StStop1: begin
          if (tick) begin
            txd_q   <= 1'b1;
            state_q <= cfg_q[2] ? StStop2 : StIdle;
          end
        end
        StStop2: begin
          if (tick) begin
            txd_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level line model predicts TXD, TxBusy,
// TxDone and RInc every cycle, plus directed checks of the documented frame shapes.
module tb_uart_tx_ctrl;
  localparam int unsigned DW   = 32;
  localparam int unsigned CB   = 8;
  localparam int unsigned DIVW = 20;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      cntrl = 4'h0;
  logic [DIVW-1:0] baud = '0;
  logic            txd, busy, done;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  uart_tx_ctrl #(
    .DATA_WIDTH(DW),
    .CHAR_BITS (CB),
    .DIV_WIDTH (DIVW)
  ) dut (
    .UCLK   (clk),
    .reset  (rst),
    .Cntrl  (cntrl),
    .BaudDiv(baud),
    .fifo   (fifo_if.master),
    .TXD    (txd),
    .TxBusy (busy),
    .TxDone (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] fq[$];          // FIFO contents, head at index 0
  logic [1:0]    exp_q[$];       // per-cycle expectation {done, txd}; busy implied
  logic [1:0]    fr[$];          // frame built by build_frame
  logic          cap[$];         // TXD captured during busy cycles
  logic          rinc_seen = 1'b0;
  int            n_busy = 0, n_rinc = 0, done_idx = 0, gap = 1000, last_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole frame as a per-cycle list: each symbol lasts div+1 cycles, done on the last cycle.
  function automatic void build_frame(input logic [CB-1:0] d, input logic [2:0] cfg,
                                      input int unsigned div);
    logic sym[$];
    fr.delete();
    sym.push_back(1'b0);
    for (int i = 0; i < CB; i++) sym.push_back(d[i]);
    if (cfg[0]) sym.push_back(cfg[1] ? ~(^d) : ^d);
    sym.push_back(1'b1);
    if (cfg[2]) sym.push_back(1'b1);
    foreach (sym[i]) for (int c = 0; c <= int'(div); c++) fr.push_back({1'b0, sym[i]});
    fr[fr.size()-1][1] = 1'b1;
  endfunction

  task automatic drive_fifo();
    fifo_if.Empty = (fq.size() == 0);
    fifo_if.RData = (fq.size() != 0) ? fq[0] : $urandom;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rinc_seen) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_stats();
    n_busy = 0; n_rinc = 0; done_idx = 0; cap.delete();
  endtask

  // Compare process: model is idle when it has no pending frame cycles.
  always @(negedge clk) begin
    logic       e_txd, e_busy, e_done, e_rinc;
    logic [1:0] rec;
    rinc_seen = fifo_if.RInc && !rst;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        e_rinc = cntrl[0] && (fq.size() != 0);
        if (e_rinc) begin
          build_frame(fq[0][CB-1:0], cntrl[3:1], int'(baud));
          foreach (fr[i]) exp_q.push_back(fr[i]);
        end
      end else begin
        rec = exp_q.pop_front();
        e_txd = rec[0]; e_busy = 1'b1; e_done = rec[1]; e_rinc = 1'b0;
      end
      chk("txd", txd, e_txd);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("rinc", fifo_if.RInc, e_rinc);
      if (busy) begin n_busy++; cap.push_back(txd); end
      if (fifo_if.RInc) n_rinc++;
      if (done) done_idx = n_busy;
      if (!busy) gap++;
      if (fifo_if.RInc) last_gap = gap;
      if (busy) gap = 0;
    end
  end

  initial begin
    logic [9:0] sym55;
    logic       ok;
    bit         timed_out;
    drive_fifo();

    // Model pins, hand-derived.
    build_frame(8'h55, 3'b000, 3);
    chk("model_len_basic", fr.size(), 40);
    chk("model_done_basic", fr[39], 2'b11);
    build_frame(8'h07, 3'b001, 0);
    chk("model_len_par", fr.size(), 11);
    chk("model_par_even", fr[9][0], 1);
    build_frame(8'h07, 3'b011, 0);
    chk("model_par_odd", fr[9][0], 0);
    build_frame(8'hA3, 3'b100, 1);
    chk("model_len_2stop", fr.size(), 22);
    chk("model_d7_2stop", fr[16][0], 1);

    run(3);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rinc", fifo_if.RInc, 0);
    rst = 1'b0;
    run(2);

    // Basic frame.
    baud = 3; cntrl = 4'h1; clr_stats();
    push(32'hDEAD_BE55);
    run(45);
    chk("basic_busy", n_busy, 40);
    chk("basic_done_idx", done_idx, 40);
    chk("basic_rinc", n_rinc, 1);
    sym55 = 10'b1010101010;
    ok = (cap.size() == 40);
    if (ok) for (int i = 0; i < 40; i++) if (cap[i] !== sym55[i/4]) ok = 1'b0;
    chk("basic_wave", ok, 1);

    // Parity even then odd.
    baud = 0; cntrl = 4'h3; clr_stats();
    push(32'h0000_0007);
    run(14);
    chk("par_even_len", n_busy, 11);
    chk("par_even_bit", (cap.size() == 11) ? cap[9] : 1'bx, 1);
    cntrl = 4'h7; clr_stats();
    push(32'hFFFF_FF07);
    run(14);
    chk("par_odd_len", n_busy, 11);
    chk("par_odd_bit", (cap.size() == 11) ? cap[9] : 1'bx, 0);

    // Two stop bits.
    cntrl = 4'h9; baud = 1; clr_stats();
    push(32'h0000_00A3);
    run(26);
    chk("stop2_len", n_busy, 22);
    chk("stop2_done_idx", done_idx, 22);
    chk("stop2_tail", (cap.size() == 22) ? {cap[18], cap[19], cap[20], cap[21]} : 4'hx, 4'hF);

    // Back-to-back with config churn during each frame.
    cntrl = 4'h1; baud = 2; clr_stats();
    push(32'h12); push(32'h34);
    run(5);
    baud = 5; cntrl = 4'hB;
    run(35);
    baud = 0; cntrl = 4'h5;
    run(70);
    chk("b2b_rinc", n_rinc, 2);
    chk("b2b_gap", last_gap, 1);

    // Gating by tx_en.
    cntrl = 4'h0; baud = 1; clr_stats();
    push(32'h5A);
    run(5);
    chk("gate_rinc", n_rinc, 0);
    chk("gate_txd", txd, 1);
    cntrl = 4'h1;
    step();
    chk("gate_start", busy, 1);
    run(4);
    cntrl = 4'h0;
    push(32'h66);
    run(30);
    chk("gate_one_pop", n_rinc, 1);
    chk("gate_left", fq.size(), 1);
    fq.delete(); drive_fifo();

    // Reset mid-frame.
    cntrl = 4'h1; baud = 1; clr_stats();
    push(32'hF0);
    run(8);
    chk("rmid_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("rmid_txd", txd, 1);
    chk("rmid_busy0", busy, 0);
    chk("rmid_rinc", fifo_if.RInc, 0);
    rst = 1'b0; clr_stats();
    run(10);
    chk("rmid_idle", n_busy, 0);
    chk("rmid_idle_txd", txd, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 8 == 0) push($urandom);
      if ($urandom % 16 == 0) cntrl = {$urandom_range(7, 0), ($urandom % 4 != 0)};
      if ($urandom % 16 == 0) baud = $urandom_range(3, 0);
      if ($urandom % 500 == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    cntrl[0] = 1'b1;
    timed_out = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (fq.size() == 0 && !busy) begin timed_out = 1'b0; break; end
    end
    chk("drain_timeout", timed_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
